// File: rtl/full_adder_core.sv
// full_adder_core: ripple-carry adder built from half-adder cells, with a
// combinational result and a one-cycle registered copy.
module full_adder_core_ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module full_adder_core_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic p, g, h;
    full_adder_core_ha u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(p), .c_o(g));
    full_adder_core_ha u_ha1 (.a_i(p), .b_i(c_i), .s_o(s_o), .c_o(h));
    assign c_o = g | h;
endmodule

module full_adder_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             en,
    output logic [WIDTH-1:0] sum_f,
    output logic             carry_f,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             valid_q
);
    // Unpacked so each link of the ripple chain is an independent net
    logic c [WIDTH+1];
    logic [WIDTH-1:0] sum_d;
    logic carry_d, valid_d;

    assign c[0] = c_in;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            full_adder_core_cell u_cell (
                .a_i(x[i]),
                .b_i(y[i]),
                .c_i(c[i]),
                .s_o(sum_f[i]),
                .c_o(c[i+1])
            );
        end
    endgenerate

    assign carry_f = c[WIDTH];

    always_comb begin
        sum_d   = en ? sum_f : sum_q;
        carry_d = en ? carry_f : carry_q;
        valid_d = en | valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_full_adder_core.sv
// tb_full_adder_core: scoreboard bench driving a 1-bit and an 8-bit adder
// against an arithmetic reference model.
module tb_full_adder_core;
    logic clk = 1'b0;
    logic rst, en;
    logic x1, y1, c1;
    logic [7:0] x8, y8;
    logic c8;
    logic s1f, k1f, s1q, k1q, v1q;
    logic [7:0] s8f, s8q;
    logic k8f, k8q, v8q;

    typedef struct {
        logic [1:0] f1;
        logic [2:0] r1;
        logic [8:0] f8;
        logic [9:0] r8;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_pass = 0;

    logic [2:0] m1;
    logic [9:0] m8;
    logic [1:0] p_f1;
    logic [8:0] p_f8;
    logic p_e, p_r;

    always #5 clk = ~clk;

    full_adder_core #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .x(x1), .y(y1), .c_in(c1), .en(en),
        .sum_f(s1f), .carry_f(k1f), .sum_q(s1q), .carry_q(k1q), .valid_q(v1q)
    );

    full_adder_core #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .x(x8), .y(y8), .c_in(c8), .en(en),
        .sum_f(s8f), .carry_f(k8f), .sum_q(s8q), .carry_q(k8q), .valid_q(v8q)
    );

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Monitor: each negedge the DUTs present a settled result for the entry
    // the driver pushed just after the preceding rising edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t t;
            t = q.pop_front();
            check("comb_w1", {8'd0, k1f, s1f}, {8'd0, t.f1});
            check("reg_w1", {7'd0, v1q, k1q, s1q}, {7'd0, t.r1});
            check("comb_w8", {1'b0, k8f, s8f}, {1'b0, t.f8});
            check("reg_w8", {v8q, k8q, s8q}, t.r8);
        end
    end

    task automatic step(input logic a1, input logic b1, input logic k1,
                        input logic [7:0] a8, input logic [7:0] b8, input logic k8,
                        input logic e, input logic r);
        exp_t t;
        @(posedge clk);
        #1;
        if (p_r) begin
            m1 = '0;
            m8 = '0;
        end else if (p_e) begin
            m1 = {1'b1, p_f1};
            m8 = {1'b1, p_f8};
        end
        if (r) begin
            m1 = '0;
            m8 = '0;
        end
        x1 = a1; y1 = b1; c1 = k1;
        x8 = a8; y8 = b8; c8 = k8;
        en = e;
        rst = r;
        t.f1 = 2'(a1) + 2'(b1) + 2'(k1);
        t.f8 = 9'(a8) + 9'(b8) + 9'(k8);
        t.r1 = m1;
        t.r8 = m8;
        q.push_back(t);
        p_f1 = t.f1;
        p_f8 = t.f8;
        p_e = e;
        p_r = r;
    endtask

    task automatic rnd_step(input logic e, input logic r);
        step(1'($urandom), 1'($urandom), 1'($urandom),
             8'($urandom), 8'($urandom), 1'($urandom), e, r);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        x1 = 0; y1 = 0; c1 = 0; x8 = '0; y8 = '0; c8 = 0;
        m1 = '0; m8 = '0; p_f1 = '0; p_f8 = '0; p_e = 1'b0; p_r = 1'b1;
        rnd_step(1'b1, 1'b1);
        rnd_step(1'b0, 1'b1);
        rnd_step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            step(v[2], v[1], v[0], 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        for (int i = 0; i < 40; i++) rnd_step(1'($urandom), 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h33, 8'h44, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) rnd_step(1'($urandom), 1'b0);
        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) $display("FAIL drain: %0d entries left, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
